// File: rtl/cpu_ram_arbiter.sv
// CPU / DMA arbiter in front of the 16K x 32 CPU RAM, with a bounded-starvation DMA grant.
// Optional CPU write protection of the low region is enabled by defining CPU_RAM_ARBITER_PROTECT_EN.
module cpu_ram_arbiter #(
  parameter int                    ADDR_WIDTH   = 14,
  parameter int                    STARVE_LIMIT = 4,
  parameter logic [ADDR_WIDTH-1:0] PROTECT_TOP  = 14'h0400
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_valid,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [3:0]            cpu_wstrb,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_ready,
  output logic [31:0]           cpu_rdata,
  input  logic                  dma_valid,
  input  logic [ADDR_WIDTH-1:0] dma_address,
  input  logic [31:0]           dma_wdata,
  output logic                  dma_ready,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_cs,
  output logic                  ram_write_en,
  output logic [3:0]            ram_wstrb,
  output logic [31:0]           ram_write_data,
  input  logic [31:0]           ram_read_data
`ifdef CPU_RAM_ARBITER_PROTECT_EN
  ,
  output logic                  cpu_write_fault
`endif
);

  typedef enum logic [1:0] {IDLE, CPU_ACK, DMA_ACK} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       cpu_ready_q, dma_ready_q;
  logic       cpu_grant, dma_grant, cpu_blocked;

`ifdef CPU_RAM_ARBITER_PROTECT_EN
  logic fault_q, fault_d;
  assign cpu_blocked     = (cpu_wstrb != 4'h0) && (cpu_address < PROTECT_TOP);
  assign cpu_write_fault = fault_q;
`else
  logic [ADDR_WIDTH-1:0] unused_protect_top;
  assign unused_protect_top = PROTECT_TOP;
  assign cpu_blocked        = 1'b0;
`endif

  // DMA can only lose while the starve counter is below the limit.
  assign cpu_grant = cpu_valid && (!dma_valid || (starve_q < LIMIT));
  assign dma_grant = dma_valid && !cpu_grant;

  assign cpu_ready = cpu_ready_q;
  assign dma_ready = dma_ready_q;
  assign cpu_rdata = ram_read_data;

  always_comb begin
    state_d        = state_q;
    starve_d       = starve_q;
    ram_cs         = 1'b0;
    ram_write_en   = 1'b0;
    ram_wstrb      = 4'h0;
    ram_address    = '0;
    ram_write_data = 32'h0;
`ifdef CPU_RAM_ARBITER_PROTECT_EN
    fault_d        = fault_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cpu_grant) begin
          ram_cs         = !reset && !cpu_blocked;
          ram_write_en   = !reset && !cpu_blocked && (cpu_wstrb != 4'h0);
          ram_wstrb      = reset ? 4'h0 : cpu_wstrb;
          ram_address    = reset ? '0 : cpu_address;
          ram_write_data = reset ? 32'h0 : cpu_wdata;
          state_d        = CPU_ACK;
          if (dma_valid && (starve_q != LIMIT)) starve_d = starve_q + 4'd1;
`ifdef CPU_RAM_ARBITER_PROTECT_EN
          if (cpu_blocked) fault_d = 1'b1;
`endif
        end else if (dma_grant) begin
          ram_cs         = !reset;
          ram_write_en   = !reset;
          ram_wstrb      = reset ? 4'h0 : 4'hF;
          ram_address    = reset ? '0 : dma_address;
          ram_write_data = reset ? 32'h0 : dma_wdata;
          state_d        = DMA_ACK;
          starve_d       = 4'd0;
        end
      end
      CPU_ACK: state_d = IDLE;
      DMA_ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= 4'd0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
`ifdef CPU_RAM_ARBITER_PROTECT_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      cpu_ready_q <= (state_d == CPU_ACK);
      dma_ready_q <= (state_d == DMA_ACK);
`ifdef CPU_RAM_ARBITER_PROTECT_EN
      fault_q     <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_ram_arbiter.sv
// Directed bench for cpu_ram_arbiter with a behavioural byte-masked RAM.
// Define CPU_RAM_ARBITER_PROTECT_EN to also cover the write-protect feature.
module tb_cpu_ram_arbiter;

  typedef struct {
    logic        cpuValid;
    logic [13:0] cpuAddr;
    logic [3:0]  cpuWstrb;
    logic [31:0] cpuWdata;
    logic        dmaValid;
    logic [13:0] dmaAddr;
    logic [31:0] dmaWdata;
    logic        expCs;
    logic        expWe;
    logic [3:0]  expWstrb;
    logic [13:0] expAddr;
    logic [31:0] expWdata;
    logic        expCpuReady;
    logic        expDmaReady;
    logic        checkRdata;
    logic [31:0] expRdata;
  } vec_t;

`ifdef CPU_RAM_ARBITER_PROTECT_EN
  localparam logic [13:0] A_WR = 14'h0410;
  localparam logic [13:0] A_BS = 14'h0420;
`else
  localparam logic [13:0] A_WR = 14'h0010;
  localparam logic [13:0] A_BS = 14'h0020;
`endif

  logic        clk, reset;
  logic        cpu_valid, cpu_ready, dma_valid, dma_ready;
  logic [13:0] cpu_address, dma_address, ram_address;
  logic [3:0]  cpu_wstrb, ram_wstrb;
  logic [31:0] cpu_wdata, cpu_rdata, dma_wdata, ram_write_data, ram_read_data;
  logic        ram_cs, ram_write_en;
`ifdef CPU_RAM_ARBITER_PROTECT_EN
  logic        cpu_write_fault;
`endif

  logic [31:0] mem [0:16383];
  int          checks = 0;
  int          errors = 0;

  cpu_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_address(cpu_address), .cpu_wstrb(cpu_wstrb),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dma_valid(dma_valid), .dma_address(dma_address), .dma_wdata(dma_wdata),
    .dma_ready(dma_ready),
    .ram_address(ram_address), .ram_cs(ram_cs), .ram_write_en(ram_write_en),
    .ram_wstrb(ram_wstrb), .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
`ifdef CPU_RAM_ARBITER_PROTECT_EN
    , .cpu_write_fault(cpu_write_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: byte-masked writes, one-cycle synchronous read.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_write_en) begin
        for (int b = 0; b < 4; b++)
          if (ram_wstrb[b]) mem[ram_address][b*8 +: 8] <= ram_write_data[b*8 +: 8];
      end else begin
        ram_read_data <= mem[ram_address];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    cpu_valid   = v.cpuValid;
    cpu_address = v.cpuAddr;
    cpu_wstrb   = v.cpuWstrb;
    cpu_wdata   = v.cpuWdata;
    dma_valid   = v.dmaValid;
    dma_address = v.dmaAddr;
    dma_wdata   = v.dmaWdata;
    #1;
    checkOutput($sformatf("v%0d ram_cs", idx), 32'(ram_cs), 32'(v.expCs));
    checkOutput($sformatf("v%0d ram_write_en", idx), 32'(ram_write_en), 32'(v.expWe));
    checkOutput($sformatf("v%0d ram_wstrb", idx), 32'(ram_wstrb), 32'(v.expWstrb));
    checkOutput($sformatf("v%0d ram_address", idx), 32'(ram_address), 32'(v.expAddr));
    checkOutput($sformatf("v%0d ram_write_data", idx), ram_write_data, v.expWdata);
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d cpu_ready", idx), 32'(cpu_ready), 32'(v.expCpuReady));
    checkOutput($sformatf("v%0d dma_ready", idx), 32'(dma_ready), 32'(v.expDmaReady));
    if (v.checkRdata) checkOutput($sformatf("v%0d cpu_rdata", idx), cpu_rdata, v.expRdata);
    cpu_valid = 1'b0;
    dma_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t cpuRead(input logic [13:0] addr, input logic [31:0] expData);
    cpuRead = '{1'b1, addr, 4'h0, 32'h0, 1'b0, 14'h0, 32'h0,
                1'b1, 1'b0, 4'h0, addr, 32'h0, 1'b1, 1'b0, 1'b1, expData};
  endfunction

  function automatic vec_t dmaWrite(input logic [13:0] addr, input logic [31:0] data);
    dmaWrite = '{1'b0, 14'h0, 4'h0, 32'h0, 1'b1, addr, data,
                 1'b1, 1'b1, 4'hF, addr, data, 1'b0, 1'b1, 1'b0, 32'h0};
  endfunction

  vec_t vectors [10];
  int   cpuWins;
  bit   dmaSeen;

  initial begin
    vectors[0] = '{1'b1, A_WR, 4'hF, 32'hDEADBEEF, 1'b0, 14'h0, 32'h0,
                   1'b1, 1'b1, 4'hF, A_WR, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0};
    vectors[1] = cpuRead(A_WR, 32'hDEADBEEF);
    vectors[2] = '{1'b1, A_BS, 4'hF, 32'h11223344, 1'b0, 14'h0, 32'h0,
                   1'b1, 1'b1, 4'hF, A_BS, 32'h11223344, 1'b1, 1'b0, 1'b0, 32'h0};
    vectors[3] = '{1'b1, A_BS, 4'h1, 32'h000000AA, 1'b0, 14'h0, 32'h0,
                   1'b1, 1'b1, 4'h1, A_BS, 32'h000000AA, 1'b1, 1'b0, 1'b0, 32'h0};
    vectors[4] = cpuRead(A_BS, 32'h112233AA);
    vectors[5] = '{1'b1, A_BS, 4'hC, 32'hAABBCCDD, 1'b0, 14'h0, 32'h0,
                   1'b1, 1'b1, 4'hC, A_BS, 32'hAABBCCDD, 1'b1, 1'b0, 1'b0, 32'h0};
    vectors[6] = cpuRead(A_BS, 32'hAABB33AA);
    vectors[7] = dmaWrite(14'h3FFF, 32'hCAFEF00D);
    vectors[8] = cpuRead(14'h3FFF, 32'hCAFEF00D);
    vectors[9] = cpuRead(A_WR, 32'hDEADBEEF);

    reset = 1'b1;
    cpu_valid = 1'b0; cpu_address = '0; cpu_wstrb = '0; cpu_wdata = '0;
    dma_valid = 1'b0; dma_address = '0; dma_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset cpu_ready", 32'(cpu_ready), 32'h0);
    checkOutput("reset dma_ready", 32'(dma_ready), 32'h0);
    checkOutput("reset ram_cs", 32'(ram_cs), 32'h0);
    checkOutput("reset ram_write_en", 32'(ram_write_en), 32'h0);
    checkOutput("reset ram_address", 32'(ram_address), 32'h0);
`ifdef CPU_RAM_ARBITER_PROTECT_EN
    checkOutput("reset cpu_write_fault", 32'(cpu_write_fault), 32'h0);
`endif

    for (int i = 0; i < 10; i++) applyStimulus(vectors[i], i);

    // Starvation: CPU requests continuously, DMA must win every fifth grant.
    cpu_valid = 1'b1; cpu_address = A_WR; cpu_wstrb = 4'h0; cpu_wdata = 32'h0;
    for (int r = 0; r < 2; r++) begin
      dma_address = 14'h3FFF - 14'(r);
      dma_wdata   = 32'hA5A5A5A5 ^ 32'(r);
      dma_valid   = 1'b1;
      cpuWins = 0;
      dmaSeen = 1'b0;
      for (int c = 0; c < 40 && !dmaSeen; c++) begin
        @(posedge clk);
        #1;
        if (cpu_ready) cpuWins++;
        if (dma_ready) dmaSeen = 1'b1;
      end
      dma_valid = 1'b0;
      checkOutput($sformatf("starve r%0d cpu wins", r), 32'(cpuWins), 32'd4);
      checkOutput($sformatf("starve r%0d dma granted", r), 32'(dmaSeen), 32'd1);
    end
    cpu_valid = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(cpuRead(14'h3FFF, 32'hA5A5A5A5), 20);
    applyStimulus(cpuRead(14'h3FFE, 32'hA5A5A5A4), 21);

    // DMA-only stream: address advances in each ack cycle.
    @(negedge clk);
    dma_address = 14'h0100; dma_wdata = 32'h10000000; dma_valid = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("stream%0d ram_wstrb", i), 32'(ram_wstrb), 32'hF);
      checkOutput($sformatf("stream%0d ram_address", i), 32'(ram_address), 32'h100 + 32'(i));
      @(posedge clk);
      #1;
      checkOutput($sformatf("stream%0d dma_ready", i), 32'(dma_ready), 32'h1);
      if (i < 7) begin
        dma_address = 14'h0100 + 14'(i + 1);
        dma_wdata   = 32'h10000000 + 32'(i + 1);
      end else begin
        dma_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      checkOutput($sformatf("stream%0d dma_ready gap", i), 32'(dma_ready), 32'h0);
    end
    for (int i = 0; i < 8; i++)
      applyStimulus(cpuRead(14'h0100 + 14'(i), 32'h10000000 + 32'(i)), 30 + i);

`ifdef CPU_RAM_ARBITER_PROTECT_EN
    applyStimulus(dmaWrite(14'h0003, 32'h0BADF00D), 40);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_address = 14'h0003; cpu_wstrb = 4'hF; cpu_wdata = 32'h12345678;
    #1;
    checkOutput("prot ram_cs", 32'(ram_cs), 32'h0);
    checkOutput("prot ram_write_en", 32'(ram_write_en), 32'h0);
    checkOutput("prot fault before ack", 32'(cpu_write_fault), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("prot cpu_ready", 32'(cpu_ready), 32'h1);
    checkOutput("prot fault in ack", 32'(cpu_write_fault), 32'h1);
    cpu_valid = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(cpuRead(14'h0003, 32'h0BADF00D), 41);
    checkOutput("prot fault sticky", 32'(cpu_write_fault), 32'h1);
    applyStimulus(dmaWrite(14'h0003, 32'h00000077), 42);
    applyStimulus(cpuRead(14'h0003, 32'h00000077), 43);
`endif

    // Reset lands in the cycle a CPU read is presented.
    @(negedge clk);
    cpu_valid = 1'b1; cpu_address = A_WR; cpu_wstrb = 4'h0; cpu_wdata = 32'h0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset cpu_ready", 32'(cpu_ready), 32'h0);
    checkOutput("midreset ram_cs", 32'(ram_cs), 32'h0);
    checkOutput("midreset ram_write_en", 32'(ram_write_en), 32'h0);
    checkOutput("midreset ram_wstrb", 32'(ram_wstrb), 32'h0);
    checkOutput("midreset ram_address", 32'(ram_address), 32'h0);
    checkOutput("midreset ram_write_data", ram_write_data, 32'h0);
`ifdef CPU_RAM_ARBITER_PROTECT_EN
    checkOutput("midreset cpu_write_fault", 32'(cpu_write_fault), 32'h0);
`endif
    reset = 1'b0;
    cpu_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("postreset cpu_ready", 32'(cpu_ready), 32'h0);
    applyStimulus(cpuRead(A_WR, 32'hDEADBEEF), 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ram_arbiter.md
Name: cpu_ram_arbiter

Overview:
- Sits directly upstream of the CPU RAM (16K x 32, two 16-bit SPRAM halves, byte-masked writes, 1-cycle synchronous read latency).
- Arbitrates between the CPU memory bus (valid/ready, read/write, byte strobes) and a write-only DMA/boot-loader port that fills RAM from flash.
- Drives the RAM address, chip-select, write-enable, strobe and data.
- Converts the RAM's fixed read latency into a ready handshake for each requester.

Parameters:
- ADDR_WIDTH, 14, word-address width; the RAM depth is 2^ADDR_WIDTH words.
- STARVE_LIMIT, 4, number of consecutive arbitration cycles DMA may lose to the CPU before it is forced a grant; range 1..15.
- PROTECT_TOP, 14'h0400, exclusive upper word address of the CPU write-protected region; used only with the optional feature.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cpu_valid  input  1  CPU request; held until cpu_ready
- cpu_address  input  ADDR_WIDTH  CPU word address
- cpu_wstrb  input  4  byte strobes; 0 = read
- cpu_wdata  input  32  CPU write data
- cpu_ready  output  1  one-cycle completion pulse
- cpu_rdata  output  32  read data, valid while cpu_ready=1 on reads
- dma_valid  input  1  DMA write request; held until dma_ready
- dma_address  input  ADDR_WIDTH  DMA word address
- dma_wdata  input  32  DMA write data; full-word write
- dma_ready  output  1  one-cycle completion pulse
- ram_address  output  ADDR_WIDTH  to RAM
- ram_cs  output  1  RAM chip select
- ram_write_en  output  1  RAM write enable
- ram_wstrb  output  4  RAM byte strobes
- ram_write_data  output  32  RAM write data
- ram_read_data  input  32  RAM read data, valid the cycle after a read is issued
- cpu_write_fault  output  1  sticky protect-violation flag; present only with CPU_RAM_ARBITER_PROTECT_EN

Behaviour:
- States: IDLE, CPU_ACK, DMA_ACK.
- Reset (sync): state IDLE, starve counter 0. cpu_ready, dma_ready, ram_cs and ram_write_en are 0. ram_wstrb is 0, ram_address is 0, ram_write_data is 0, cpu_write_fault is 0.
- Reset asserted mid-transaction aborts it; no ready pulse is issued for the aborted access.
- RAM drive signals are combinational from state and inputs. A RAM access is issued only in IDLE; the RAM is not selected in any other state.
- IDLE, grant CPU when cpu_valid=1 and (dma_valid=0 or starve counter < STARVE_LIMIT):
  - Issue ram_cs=1, ram_address=cpu_address, ram_write_en=(cpu_wstrb!=0), ram_wstrb=cpu_wstrb, ram_write_data=cpu_wdata.
  - Go to CPU_ACK.
  - If dma_valid=1, starve counter increments, saturating at STARVE_LIMIT.
- IDLE, grant DMA when dma_valid=1 and (cpu_valid=0 or starve counter == STARVE_LIMIT):
  - Issue ram_cs=1, ram_write_en=1, ram_wstrb=4'hF, ram_address=dma_address, ram_write_data=dma_wdata.
  - Go to DMA_ACK; starve counter clears to 0.
- IDLE with no request: no RAM access; state and counter hold.
- CPU_ACK (exactly one cycle): cpu_ready=1, cpu_rdata=ram_read_data (pass-through, combinational); next state IDLE.
- DMA_ACK (exactly one cycle): dma_ready=1; next state IDLE.
- Latency: the request is accepted in cycle N and ready is asserted in cycle N+1, for reads and writes alike. Back-to-back accesses from one requester therefore take 2 cycles each.
- Requester rule: valid deasserts or changes the cycle after ready. The arbiter never grants in an ACK state, so a stale valid in that cycle cannot cause a double access.
- cpu_rdata outside CPU_ACK is don't-care; the bench checks it only while cpu_ready=1.
- Address wrap: the address is used as-is, so the maximum address 2^ADDR_WIDTH-1 is legal. There is no boundary check.

Optional Feature:
- Macro: CPU_RAM_ARBITER_PROTECT_EN.
- Defined: a CPU write (cpu_wstrb!=0) with cpu_address < PROTECT_TOP is granted and acked normally, but issues ram_cs=0 and ram_write_en=0.
  - cpu_write_fault sets in the CPU_ACK cycle of that write and stays 1 until reset.
  - CPU reads and all DMA writes to the region are unaffected.
- Undefined: there is no protection, PROTECT_TOP is ignored, and the cpu_write_fault port does not exist.

Test Plan:
- CPU write then read: write 32'hDEADBEEF, wstrb 4'hF to address 14'h0010 (cycle N, ram_cs=1, ram_write_en=1, cpu_ready at N+1); then read 14'h0010 -> cpu_rdata=32'hDEADBEEF with cpu_ready.
- Byte strobe: write 32'h000000AA with wstrb 4'h1 over 32'h11223344 -> read returns 32'h112233AA.
- Simultaneous requests with starvation: CPU continuously valid, DMA valid, STARVE_LIMIT=4 -> CPU wins 4 grants, DMA wins the 5th, starve counter returns to 0; DMA address 14'h3FFF is written correctly.
- DMA-only stream: 8 sequential writes to 14'h0100..14'h0107 -> dma_ready every 2nd cycle, ram_wstrb=4'hF, CPU reads return the written data.
- Reset mid-op: assert reset in the cycle a CPU read is issued -> next cycle cpu_ready=0, state IDLE, all RAM drive outputs 0.
- With CPU_RAM_ARBITER_PROTECT_EN: CPU write 32'h12345678 to 14'h0003 -> acked, ram_cs=0, cpu_write_fault=1 and sticky. Read of 14'h0003 returns the prior contents. DMA write to 14'h0003 succeeds.
